grid_game_controller: RTL and testbench

- Parametrised successor of the tic-tac-toe block controller: an N x N two-player placement game with a K-in-a-row win rule.
- Registers the cursor, both players' occupancy maps, the move count and the turn owner.
- Detects wins and draws and drives cursor pixel coordinates to the VGA rgb mux.
- Sits between the debounced button synchronisers and the display/rgb logic. Fully clocked; no combinational state updates.

---
 rtl/grid_game_pkg.sv | 30 +++
 rtl/grid_line_detect.sv | 44 ++++
 rtl/grid_game_controller.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_grid_game_controller.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_game_pkg.sv
// grid_game_pkg
// Shared definitions for the grid game controller:
//   - one-hot state encodings (bit order {DRAW,WIN,CHECK,TURN,IDLE})
//   - winner encodings
//   - idx(row, col, n): row-major cell index into an n x n occupancy map
package grid_game_pkg;

    localparam logic [4:0] OH_IDLE  = 5'b00001;
    localparam logic [4:0] OH_TURN  = 5'b00010;
    localparam logic [4:0] OH_CHECK = 5'b00100;
    localparam logic [4:0] OH_WIN   = 5'b01000;
    localparam logic [4:0] OH_DRAW  = 5'b10000;

    typedef enum logic [4:0] {
        ST_IDLE  = OH_IDLE,
        ST_TURN  = OH_TURN,
        ST_CHECK = OH_CHECK,
        ST_WIN   = OH_WIN,
        ST_DRAW  = OH_DRAW
    } state_e;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    function automatic int idx(input int row, input int col, input int n);
        return row * n + col;
    endfunction

endpackage

// File: rtl/grid_line_detect.sv
// grid_line_detect
// Purely combinational K-in-a-row detector for one player's occupancy map.
// Ports:
//   board_i  in  BOARD_N*BOARD_N  occupancy, bit r*BOARD_N+c
//   win_o    out 1                a horizontal, vertical, diagonal or
//                                 anti-diagonal run of WIN_LEN set cells exists
module grid_line_detect #(
    parameter int BOARD_N = 3,
    parameter int WIN_LEN = 3
) (
    input  logic [BOARD_N*BOARD_N-1:0] board_i,
    output logic                       win_o
);

    localparam int NN = BOARD_N * BOARD_N;

    // One candidate run per (direction, start cell); starts whose run would
    // leave the board tie their hit bit low.
    // Directions: 0 = right, 1 = down, 2 = down-right, 3 = down-left.
    logic [4*NN-1:0] hits;

    for (genvar gd = 0; gd < 4; gd++) begin : g_dir
        localparam int DR = (gd == 0) ? 0 : 1;
        localparam int DC = (gd == 0) ? 1 : (gd == 1) ? 0 : (gd == 2) ? 1 : -1;
        for (genvar gr = 0; gr < BOARD_N; gr++) begin : g_row
            for (genvar gc = 0; gc < BOARD_N; gc++) begin : g_col
                localparam int ER = gr + (WIN_LEN - 1) * DR;
                localparam int EC = gc + (WIN_LEN - 1) * DC;
                if (ER < BOARD_N && EC >= 0 && EC < BOARD_N) begin : g_fit
                    logic [WIN_LEN-1:0] run;
                    for (genvar gk = 0; gk < WIN_LEN; gk++) begin : g_k
                        assign run[gk] = board_i[(gr + gk * DR) * BOARD_N + gc + gk * DC];
                    end
                    assign hits[gd * NN + gr * BOARD_N + gc] = &run;
                end else begin : g_nofit
                    assign hits[gd * NN + gr * BOARD_N + gc] = 1'b0;
                end
            end
        end
    end

    assign win_o = |hits;

endmodule

// File: rtl/grid_game_controller.sv
// grid_game_controller
// N x N two-player placement game with a K-in-a-row win rule. Holds the
// cursor, both occupancy maps, move count and turn owner; detects wins and
// draws; drives the cursor cell centre in pixels to the rgb mux.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start, first_p2            start a game (IDLE/WIN/DRAW); first mover select
//   up, down, left, right,     debounced button levels, rising-edge detected
//   place
//   undo                       (UNDO_EN only) one-level undo of last placement
//   cursor_row, cursor_col     cursor cell
//   cursor_x, cursor_y         cursor cell centre in pixels
//   board_p1, board_p2         occupancy maps, bit r*BOARD_N+c
//   cur_player                 0 = player 1 to move
//   move_cnt                   pieces on the board
//   illegal                    one-cycle pulse on place to an occupied cell
//   winner                     00 none, 01 P1, 10 P2
//   state_oh                   one-hot {DRAW,WIN,CHECK,TURN,IDLE}
// Build option: define UNDO_EN to add the undo input and its slot registers.
//
// state | meaning
// IDLE  | after reset, waiting for start
// TURN  | current player moves the cursor / places a piece
// CHECK | one cycle: evaluate the mover's board for win or draw
// WIN   | board frozen, winner valid, waiting for start
// DRAW  | board full with no line, waiting for start
module grid_game_controller
    import grid_game_pkg::*;
#(
    parameter int BOARD_N  = 3,
    parameter int WIN_LEN  = 3,
    parameter int CELL_PX  = 150,
    parameter int ORIGIN_X = 300,
    parameter int ORIGIN_Y = 100,
    localparam int IDX_W   = $clog2(BOARD_N * BOARD_N)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         first_p2,
    input  logic                         up,
    input  logic                         down,
    input  logic                         left,
    input  logic                         right,
    input  logic                         place,
`ifdef UNDO_EN
    input  logic                         undo,
`endif
    output logic [$clog2(BOARD_N)-1:0]   cursor_row,
    output logic [$clog2(BOARD_N)-1:0]   cursor_col,
    output logic [9:0]                   cursor_x,
    output logic [9:0]                   cursor_y,
    output logic [BOARD_N*BOARD_N-1:0]   board_p1,
    output logic [BOARD_N*BOARD_N-1:0]   board_p2,
    output logic                         cur_player,
    output logic [IDX_W:0]               move_cnt,
    output logic                         illegal,
    output logic [1:0]                   winner,
    output logic [4:0]                   state_oh
);

    localparam int NN   = BOARD_N * BOARD_N;
    localparam int RC_W = $clog2(BOARD_N);

    localparam logic [RC_W-1:0]  RC_MAX  = RC_W'(BOARD_N - 1);
    localparam logic [RC_W-1:0]  RC_ONE  = RC_W'(1);
    localparam logic [IDX_W:0]   CNT_ONE = (IDX_W + 1)'(1);
    localparam logic [IDX_W:0]   CELLS   = (IDX_W + 1)'(NN);

    // Button vector bit positions
    localparam int B_DOWN  = 0;
    localparam int B_UP    = 1;
    localparam int B_LEFT  = 2;
    localparam int B_RIGHT = 3;
    localparam int B_PLACE = 4;

    function automatic logic [9:0] pix(input logic [RC_W-1:0] rc, input int origin);
        return 10'(origin + int'(rc) * CELL_PX + CELL_PX / 2);
    endfunction

    function automatic logic [NN-1:0] cell_bit(input logic [RC_W-1:0] r,
                                               input logic [RC_W-1:0] c);
        return {{(NN-1){1'b0}}, 1'b1} << idx(int'(r), int'(c), BOARD_N);
    endfunction

    state_e              state_q, state_d;
    logic [RC_W-1:0]     row_q, row_d, col_q, col_d;
    logic [9:0]          cx_q, cx_d, cy_q, cy_d;
    logic [NN-1:0]       board_p1_q, board_p1_d, board_p2_q, board_p2_d;
    logic                cur_player_q, cur_player_d;
    logic [IDX_W:0]      move_cnt_q, move_cnt_d;
    logic                illegal_q, illegal_d;
    logic [1:0]          winner_q, winner_d;
    logic [4:0]          btn_q, btn_d;

    logic [4:0]          btn_edge;
    logic [NN-1:0]       cur_mask;
    logic [NN-1:0]       mover_board;
    logic                line_win;

`ifdef UNDO_EN
    logic                undo_q, undo_d;
    logic                slot_valid_q, slot_valid_d;
    logic [RC_W-1:0]     slot_row_q, slot_row_d, slot_col_q, slot_col_d;
    logic                slot_player_q, slot_player_d;
    logic                undo_ok;
    logic [NN-1:0]       slot_mask;

    assign undo_ok   = undo & ~undo_q & slot_valid_q & (move_cnt_q != '0);
    assign slot_mask = cell_bit(slot_row_q, slot_col_q);
`endif

    assign btn_edge    = {place, right, left, up, down} & ~btn_q;
    assign cur_mask    = cell_bit(row_q, col_q);
    assign mover_board = cur_player_q ? board_p2_q : board_p1_q;

    grid_line_detect #(
        .BOARD_N (BOARD_N),
        .WIN_LEN (WIN_LEN)
    ) u_line_detect (
        .board_i (mover_board),
        .win_o   (line_win)
    );

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        board_p1_d   = board_p1_q;
        board_p2_d   = board_p2_q;
        cur_player_d = cur_player_q;
        move_cnt_d   = move_cnt_q;
        illegal_d    = 1'b0;
        winner_d     = winner_q;
        btn_d        = {place, right, left, up, down};
`ifdef UNDO_EN
        undo_d        = undo;
        slot_valid_d  = slot_valid_q;
        slot_row_d    = slot_row_q;
        slot_col_d    = slot_col_q;
        slot_player_d = slot_player_q;
`endif

        case (state_q)
            ST_IDLE, ST_WIN, ST_DRAW: begin
                if (start) begin
                    board_p1_d   = '0;
                    board_p2_d   = '0;
                    move_cnt_d   = '0;
                    winner_d     = WIN_NONE;
                    row_d        = '0;
                    col_d        = '0;
                    cur_player_d = first_p2;
                    state_d      = ST_TURN;
`ifdef UNDO_EN
                    slot_valid_d = 1'b0;
`endif
                end
            end

            ST_TURN: begin
                if (btn_edge[B_PLACE]) begin
                    if (|((board_p1_q | board_p2_q) & cur_mask)) begin
                        illegal_d = 1'b1;
                    end else begin
                        if (cur_player_q) board_p2_d = board_p2_q | cur_mask;
                        else              board_p1_d = board_p1_q | cur_mask;
                        move_cnt_d = move_cnt_q + CNT_ONE;
                        state_d    = ST_CHECK;
`ifdef UNDO_EN
                        slot_valid_d  = 1'b1;
                        slot_row_d    = row_q;
                        slot_col_d    = col_q;
                        slot_player_d = cur_player_q;
`endif
                    end
                end
`ifdef UNDO_EN
                else if (undo_ok) begin
                    if (slot_player_q) board_p2_d = board_p2_q & ~slot_mask;
                    else               board_p1_d = board_p1_q & ~slot_mask;
                    move_cnt_d   = move_cnt_q - CNT_ONE;
                    cur_player_d = slot_player_q;
                    row_d        = slot_row_q;
                    col_d        = slot_col_q;
                    slot_valid_d = 1'b0;
                end
`endif
                else if (btn_edge[B_RIGHT]) begin
                    col_d = (col_q == RC_MAX) ? '0 : col_q + RC_ONE;
                end else if (btn_edge[B_LEFT]) begin
                    col_d = (col_q == '0) ? RC_MAX : col_q - RC_ONE;
                end else if (btn_edge[B_UP]) begin
                    row_d = (row_q == '0) ? RC_MAX : row_q - RC_ONE;
                end else if (btn_edge[B_DOWN]) begin
                    row_d = (row_q == RC_MAX) ? '0 : row_q + RC_ONE;
                end
            end

            ST_CHECK: begin
                // A line on the last cell wins even though the board is full.
                if (line_win) begin
                    winner_d = cur_player_q ? WIN_P2 : WIN_P1;
                    state_d  = ST_WIN;
                end else if (move_cnt_q == CELLS) begin
                    state_d = ST_DRAW;
                end else begin
                    cur_player_d = ~cur_player_q;
                    state_d      = ST_TURN;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Pixel centres track the next cursor cell so they change with row/col.
        cx_d = pix(col_d, ORIGIN_X);
        cy_d = pix(row_d, ORIGIN_Y);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            col_q        <= '0;
            cx_q         <= pix('0, ORIGIN_X);
            cy_q         <= pix('0, ORIGIN_Y);
            board_p1_q   <= '0;
            board_p2_q   <= '0;
            cur_player_q <= 1'b0;
            move_cnt_q   <= '0;
            illegal_q    <= 1'b0;
            winner_q     <= WIN_NONE;
            btn_q        <= '0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            board_p1_q   <= board_p1_d;
            board_p2_q   <= board_p2_d;
            cur_player_q <= cur_player_d;
            move_cnt_q   <= move_cnt_d;
            illegal_q    <= illegal_d;
            winner_q     <= winner_d;
            btn_q        <= btn_d;
        end
    end

`ifdef UNDO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            undo_q        <= 1'b0;
            slot_valid_q  <= 1'b0;
            slot_row_q    <= '0;
            slot_col_q    <= '0;
            slot_player_q <= 1'b0;
        end else begin
            undo_q        <= undo_d;
            slot_valid_q  <= slot_valid_d;
            slot_row_q    <= slot_row_d;
            slot_col_q    <= slot_col_d;
            slot_player_q <= slot_player_d;
        end
    end
`endif

    assign cursor_row = row_q;
    assign cursor_col = col_q;
    assign cursor_x   = cx_q;
    assign cursor_y   = cy_q;
    assign board_p1   = board_p1_q;
    assign board_p2   = board_p2_q;
    assign cur_player = cur_player_q;
    assign move_cnt   = move_cnt_q;
    assign illegal    = illegal_q;
    assign winner     = winner_q;
    assign state_oh   = state_q;

endmodule

// File: tb/tb_grid_game_controller.sv
// tb_grid_game_controller
// Directed bench: a 3x3 / 3-in-a-row instance and a 4x4 / 3-in-a-row
// instance share one set of button drivers, steered by sel4.
module tb_grid_game_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic start = 1'b0, first_p2 = 1'b0;
    logic b_up = 1'b0, b_down = 1'b0, b_left = 1'b0, b_right = 1'b0, b_place = 1'b0;
    logic b_undo = 1'b0;
    logic sel4 = 1'b0;

    logic [1:0] r3, c3;
    logic [9:0] x3, y3;
    logic [8:0] bp1_3, bp2_3;
    logic       pl3, il3;
    logic [4:0] mc3, st3;
    logic [1:0] w3;

    logic [1:0]  r4, c4;
    logic [9:0]  x4, y4;
    logic [15:0] bp1_4, bp2_4;
    logic        pl4, il4;
    logic [4:0]  mc4, st4;
    logic [1:0]  w4;

    grid_game_controller #(.BOARD_N(3), .WIN_LEN(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .start(start & ~sel4), .first_p2(first_p2),
        .up(b_up & ~sel4), .down(b_down & ~sel4), .left(b_left & ~sel4),
        .right(b_right & ~sel4), .place(b_place & ~sel4),
`ifdef UNDO_EN
        .undo(b_undo & ~sel4),
`endif
        .cursor_row(r3), .cursor_col(c3), .cursor_x(x3), .cursor_y(y3),
        .board_p1(bp1_3), .board_p2(bp2_3), .cur_player(pl3),
        .move_cnt(mc3), .illegal(il3), .winner(w3), .state_oh(st3)
    );

    grid_game_controller #(.BOARD_N(4), .WIN_LEN(3)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .start(start & sel4), .first_p2(first_p2),
        .up(b_up & sel4), .down(b_down & sel4), .left(b_left & sel4),
        .right(b_right & sel4), .place(b_place & sel4),
`ifdef UNDO_EN
        .undo(b_undo & sel4),
`endif
        .cursor_row(r4), .cursor_col(c4), .cursor_x(x4), .cursor_y(y4),
        .board_p1(bp1_4), .board_p2(bp2_4), .cur_player(pl4),
        .move_cnt(mc4), .illegal(il4), .winner(w4), .state_oh(st4)
    );

    localparam int S_IDLE = 1, S_TURN = 2, S_CHECK = 4, S_WIN = 8, S_DRAW = 16;

    int n_cmp = 0;
    int n_bad = 0;
    int mr = 0, mc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // 0 up, 1 down, 2 left, 3 right, 4 place, 5 undo; one-cycle high level
    task automatic pulse(input int which);
        @(negedge clk);
        case (which)
            0: b_up = 1'b1;
            1: b_down = 1'b1;
            2: b_left = 1'b1;
            3: b_right = 1'b1;
            4: b_place = 1'b1;
            default: b_undo = 1'b1;
        endcase
        @(negedge clk);
        b_up = 1'b0; b_down = 1'b0; b_left = 1'b0;
        b_right = 1'b0; b_place = 1'b0; b_undo = 1'b0;
    endtask

    task automatic start_game(input logic p2);
        @(negedge clk);
        start = 1'b1;
        first_p2 = p2;
        @(negedge clk);
        start = 1'b0;
        mr = 0;
        mc = 0;
    endtask

    task automatic nav(input int r, input int c, input int n);
        while (mc != c) begin pulse(3); mc = (mc + 1) % n; end
        while (mr != r) begin pulse(1); mr = (mr + 1) % n; end
    endtask

    task automatic place_at(input int r, input int c, input int n);
        nav(r, c, n);
        pulse(4);
        @(negedge clk);
    endtask

    int draw_cells[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_state", st3, S_IDLE);
        chk("rst_boards", {bp1_3, bp2_3}, 0);
        chk("rst_cursor", {r3, c3}, 0);
        chk("rst_cx", x3, 375);
        chk("rst_cnt_pl_win_ill", {mc3, pl3, w3, il3}, 0);
        rst_n = 1'b1;

        // Start, cursor at (0,0)
        start_game(1'b0);
        chk("start_state", st3, S_TURN);
        chk("start_cursor", {r3, c3}, 0);
        chk("start_cx", x3, 375);
        chk("start_cy", y3, 175);
        chk("start_player", pl3, 0);

        // Wrapping left and up
        pulse(2);
        pulse(0);
        mr = 2; mc = 2;
        chk("wrap_row", r3, 2);
        chk("wrap_col", c3, 2);
        chk("wrap_cx", x3, 675);
        chk("wrap_cy", y3, 475);

        // Right held 10 cycles moves exactly once (2 -> 0)
        @(negedge clk);
        b_right = 1'b1;
        repeat (10) @(negedge clk);
        b_right = 1'b0;
        @(negedge clk);
        mc = 0;
        chk("held_col", c3, 0);
        chk("held_cx", x3, 375);
        chk("held_row", r3, 2);

        // P1: 0,1,2  P2: 3,4
        place_at(0, 0, 3);
        chk("p1a_player", pl3, 1);
        chk("p1a_board", bp1_3, 9'h001);
        place_at(1, 0, 3);
        chk("p2a_player", pl3, 0);
        place_at(0, 1, 3);
        place_at(1, 1, 3);
        chk("p2b_board", bp2_3, 9'h018);
        chk("p2b_cnt", mc3, 4);
        nav(0, 2, 3);
        pulse(4);
        chk("win_check_state", st3, S_CHECK);
        chk("win_not_yet", w3, 0);
        @(negedge clk);
        chk("win_state", st3, S_WIN);
        chk("win_winner", w3, 1);
        chk("win_p1", bp1_3, 9'h007);
        chk("win_cnt", mc3, 5);

        // Frozen in WIN
        pulse(3);
        pulse(4);
        pulse(1);
        chk("frozen_col", c3, 2);
        chk("frozen_row", r3, 0);
        chk("frozen_boards", {bp1_3, bp2_3}, {9'h007, 9'h018});
        chk("frozen_state", st3, S_WIN);

        // Illegal place on an occupied cell
        start_game(1'b0);
        chk("restart_clear", {bp1_3, bp2_3, mc3, w3}, 0);
        place_at(1, 1, 3);
        chk("ill_pre_player", pl3, 1);
        pulse(4);
        chk("ill_pulse", il3, 1);
        chk("ill_state", st3, S_TURN);
        @(negedge clk);
        chk("ill_one_cycle", il3, 0);
        chk("ill_cnt", mc3, 1);
        chk("ill_player", pl3, 1);
        chk("ill_p2_board", bp2_3, 0);

        // Asynchronous reset mid-game
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_state", st3, S_IDLE);
        chk("midrst_all", {bp1_3, bp2_3, mc3, r3, c3, pl3}, 0);
        chk("midrst_cx", x3, 375);
        @(negedge clk);
        rst_n = 1'b1;

        // Draw, player 2 first
        start_game(1'b1);
        chk("draw_first", pl3, 1);
        for (int i = 0; i < 9; i++) begin
            place_at(draw_cells[i] / 3, draw_cells[i] % 3, 3);
        end
        chk("draw_state", st3, S_DRAW);
        chk("draw_cnt", mc3, 9);
        chk("draw_winner", w3, 0);
        chk("draw_p2", bp2_3, 9'd397);
        chk("draw_p1", bp1_3, 9'd114);

        // 4x4 anti-diagonal 3,6,9
        sel4 = 1'b1;
        start_game(1'b0);
        chk("b4_start", st4, S_TURN);
        place_at(0, 3, 4);
        place_at(0, 0, 4);
        place_at(1, 2, 4);
        place_at(0, 1, 4);
        nav(2, 1, 4);
        chk("b4_cx", x4, 525);
        chk("b4_cy", y4, 475);
        pulse(4);
        @(negedge clk);
        chk("b4_state", st4, S_WIN);
        chk("b4_winner", w4, 1);
        chk("b4_p1", bp1_4, 16'd584);
        chk("b4_p2", bp2_4, 16'd3);
        chk("b4_cnt", mc4, 5);
        chk("b3_untouched", st3, S_DRAW);
        sel4 = 1'b0;

`ifdef UNDO_EN
        start_game(1'b0);
        place_at(1, 1, 3);
        chk("undo_pre_player", pl3, 1);
        nav(0, 0, 3);
        pulse(5);
        mr = 1; mc = 1;
        chk("undo_board", bp1_3, 0);
        chk("undo_cnt", mc3, 0);
        chk("undo_player", pl3, 0);
        chk("undo_cursor", {r3, c3}, {2'd1, 2'd1});
        pulse(5);
        chk("undo2_cnt", mc3, 0);
        chk("undo2_state", st3, S_TURN);
        place_at(1, 1, 3);
        place_at(2, 2, 3);
        pulse(5);
        pulse(5);
        chk("undo_one_level_cnt", mc3, 1);
        chk("undo_one_level_p1", bp1_3, 9'h010);
        chk("undo_one_level_p2", bp2_3, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
